pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080, is the PC value loaded on a misaligned jump-register target; it is used only when the configuration macro is defined.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the reset; synchronous, active-low.
REQ-005 fetch_req  output  1  requests the instruction at fetch_addr.
REQ-006 fetch_addr  output  32  is the fetch address and equals pc.
REQ-007 fetch_ack  input  1  indicates instruction memory has accepted the fetch and returned data.
REQ-008 instr_valid  output  1  indicates the fetched instruction is being executed.
REQ-009 commit  input  1  indicates the datapath has retired the current instruction, with the control inputs below valid.
REQ-010 br_taken  input  1  selects the branch target.
REQ-011 br_imm  input  16  is the signed word offset of the branch.
REQ-012 jmp  input  1  selects the direct jump target.
REQ-013 jmp_target  input  26  is the jump target field.
REQ-014 jr  input  1  selects the register jump target.
REQ-015 jr_addr  input  32  is the register jump address.
REQ-016 halt  input  1  requests a stop after the current commit.
REQ-017 pc  output  32  is the current program counter.
REQ-018 pc_plus4  output  32  is pc+4, modulo 2^32.
REQ-019 state  output  2  encodes the FSM state: IDLE=0, FETCH=1, EXEC=2, HALTED=3.
REQ-020 trap  output  1  is a one-cycle misalignment pulse.

Function
REQ-021 The FSM has four transitions: IDLE->FETCH unconditionally after one cycle; FETCH->EXEC when fetch_ack=1; EXEC->FETCH on commit=1 with halt=0; EXEC->HALTED on commit=1 with halt=1.
REQ-022 FETCH holds when fetch_ack=0, and EXEC holds when commit=0; pc is unchanged while holding.
REQ-023 HALTED is terminal until reset, and all inputs are ignored in HALTED.
REQ-024 fetch_req=1 only in FETCH, and instr_valid=1 only in EXEC, both decoded combinationally from state.
REQ-025 fetch_ack outside FETCH and commit outside EXEC are ignored.
REQ-026 pc updates only on the clock edge where state=EXEC and commit=1, including the halting commit; the new value is visible the next cycle.
REQ-027 Next-PC selection priority is jr > jmp > br_taken > sequential; lower-priority selects asserted simultaneously are ignored.
REQ-028 The sequential next PC is pc_plus4, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-029 The branch next PC is pc_plus4 + {sign-extended br_imm, 2'b00}, truncated to 32 bits with wrap-around.
REQ-030 The jump next PC is {pc_plus4[31:28], jmp_target, 2'b00}.
REQ-031 The jump-register next PC is jr_addr, subject to REQ-038/039.
REQ-032 Latency: exactly one cycle from commit to FETCH with the new pc, so the minimum instruction period is two cycles.

Reset
REQ-033 While rst_n=0 at a rising edge, the block sets pc=RESET_VECTOR, state=IDLE and trap=0.
REQ-034 Reset values of the remaining outputs follow from REQ-033: fetch_req=0, instr_valid=0, pc_plus4=RESET_VECTOR+4, fetch_addr=RESET_VECTOR.
REQ-035 Reset asserted mid-operation in any state, including HALTED or FETCH with an outstanding request, overrides all other inputs on that edge.
REQ-036 A pending commit is discarded when reset is asserted on the same edge.

Configuration
REQ-037 The macro PC_SEQUENCER_MISALIGN_TRAP_EN compiles in misaligned-target trapping.
REQ-038 With the macro defined, a selected jr with jr_addr[1:0]!=2'b00 loads TRAP_VECTOR into pc and sets trap=1 for exactly the following cycle; the FSM proceeds as for a normal commit (FETCH, or HALTED if halt=1).
REQ-039 Without the macro, a selected jr loads {jr_addr[31:2], 2'b00}, trap is tied to 0, and TRAP_VECTOR is unused.

Verification
REQ-040 Reset then fetch_ack=1 and commit=1 with no selects, three times -> fetch_addr sequence 0x0, 0x4, 0x8, 0xC, with state sequence IDLE, FETCH, EXEC, FETCH, and so on.
REQ-041 At pc=0x0000_1000, commit with br_taken=1 and br_imm=16'hFFFF -> next pc=0x0000_1000; with br_imm=16'h0003 -> next pc=0x0000_1010.
REQ-042 At pc=0x3000_0000, commit with jmp=1, br_taken=1 and jmp_target=26'h000_0010 -> next pc=0x3000_0040, and the branch is ignored.
REQ-043 Commit with jr=1, jmp=1 and jr_addr=0x0000_2002 -> with the macro, pc=0x0000_0080 and trap high one cycle; without the macro, pc=0x0000_2000 and trap=0.
REQ-044 At pc=0xFFFF_FFFC, sequential commit -> pc=0x0000_0000.
REQ-045 Commit with halt=1 -> state=HALTED and fetch_req stays 0 under further fetch_ack/commit; rst_n=0 for one edge -> pc=RESET_VECTOR, state=IDLE.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake, commit controls and PC status between sequencer and datapath.
interface pc_sequencer_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        instr_valid;
  logic        commit;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  state;
  logic        trap;
  modport master (
    output fetch_req, fetch_addr, instr_valid, pc, pc_plus4, state, trap,
    input  fetch_ack, commit, br_taken, br_imm, jmp, jmp_target, jr, jr_addr, halt
  );
  modport slave (
    input  fetch_req, fetch_addr, instr_valid, pc, pc_plus4, state, trap,
    output fetch_ack, commit, br_taken, br_imm, jmp, jmp_target, jr, jr_addr, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute PC sequencer with branch, jump, jump-register and halt.
// Define PC_SEQUENCER_MISALIGN_TRAP_EN to trap misaligned jump-register targets to TRAP_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALTED = 2'd3} state_t;
  state_t      cur, nxt;
  logic [31:0] pc_q, seq_pc, br_pc, jmp_pc, jr_pc, next_pc;
  logic        take;
  assign seq_pc = pc_q + 32'd4;
  assign br_pc  = seq_pc + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign jmp_pc = {seq_pc[31:28], bus.jmp_target, 2'b00};
  assign take   = (cur == EXEC) && bus.commit;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
  logic trap_q, jr_trap;
  assign jr_trap = bus.jr && (bus.jr_addr[1:0] != 2'b00);
  assign jr_pc   = jr_trap ? TRAP_VECTOR : bus.jr_addr;
  always_ff @(posedge clk)
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= take && jr_trap;
  assign bus.trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = ^{bus.jr_addr[1:0], TRAP_VECTOR};
  assign jr_pc    = {bus.jr_addr[31:2], 2'b00};
  assign bus.trap = 1'b0;
`endif
  assign next_pc = bus.jr ? jr_pc : bus.jmp ? jmp_pc : bus.br_taken ? br_pc : seq_pc;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cur  <= IDLE;
      pc_q <= RESET_VECTOR;
    end else begin
      cur <= nxt;
      if (take) pc_q <= next_pc;
    end
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = FETCH;
      FETCH:   nxt = bus.fetch_ack ? EXEC : FETCH;
      EXEC:    nxt = !bus.commit ? EXEC : bus.halt ? HALTED : FETCH;
      default: nxt = HALTED;
    endcase
  end
  assign bus.fetch_req   = (cur == FETCH);
  assign bus.instr_valid = (cur == EXEC);
  assign bus.fetch_addr  = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = seq_pc;
  assign bus.state       = cur;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized run against a behavioural PC model.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  pc_sequencer_if bus();
  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        rn, ack, cm, br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] tgt;
    logic        jr;
    logic [31:0] ja;
    logic        halt;
    logic [1:0]  es;
    logic [31:0] epc;
    logic        et;
  } vec_t;

  int total = 0;
  int bad = 0;
  int m_st;
  logic [31:0] m_pc;
  logic m_trap;
  vec_t vecs[$];

  function automatic vec_t v(input logic rn, ack, cm, br, input logic [15:0] imm, input logic jmp,
                             input logic [25:0] tgt, input logic jr, input logic [31:0] ja,
                             input logic halt, input logic [1:0] es, input logic [31:0] epc, input logic et);
    vec_t r;
    r.rn = rn; r.ack = ack; r.cm = cm; r.br = br; r.imm = imm; r.jmp = jmp; r.tgt = tgt;
    r.jr = jr; r.ja = ja; r.halt = halt; r.es = es; r.epc = epc; r.et = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input logic [31:0] epc, input logic et);
    chk({tag, ".state"}, 32'(bus.state), 32'(es));
    chk({tag, ".pc"}, bus.pc, epc);
    chk({tag, ".fetch_addr"}, bus.fetch_addr, epc);
    chk({tag, ".pc_plus4"}, bus.pc_plus4, epc + 32'd4);
    chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'(es == 1));
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(es == 2));
    chk({tag, ".trap"}, 32'(bus.trap), 32'(et));
  endtask

  // Reference model advanced by one clock from the inputs currently applied.
  task automatic tick();
    logic [31:0] seq, np;
    if (!rst_n) begin
      m_st = 0; m_pc = RV; m_trap = 1'b0;
    end else begin
      m_trap = 1'b0;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1 && bus.fetch_ack) m_st = 2;
      else if (m_st == 2 && bus.commit) begin
        seq = m_pc + 32'd4;
        if (bus.jr) begin
          if (TRAP_EN && bus.jr_addr % 4 != 0) begin np = TV; m_trap = 1'b1; end
          else np = bus.jr_addr - (bus.jr_addr % 4);
        end else if (bus.jmp) np = {seq[31:28], bus.jmp_target, 2'b00};
        else if (bus.br_taken) np = seq + 32'(int'($signed(bus.br_imm)) * 4);
        else np = seq;
        m_pc = np;
        m_st = bus.halt ? 3 : 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    rst_n = x.rn; bus.fetch_ack = x.ack; bus.commit = x.cm; bus.br_taken = x.br; bus.br_imm = x.imm;
    bus.jmp = x.jmp; bus.jmp_target = x.tgt; bus.jr = x.jr; bus.jr_addr = x.ja; bus.halt = x.halt;
  endtask

  initial begin
    logic [31:0] tpc;
    vec_t r;
    tpc = TRAP_EN ? 32'h0000_0080 : 32'h0000_2000;
    vecs.push_back(v(0,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd0, 32'h0, 0));
    vecs.push_back(v(1,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, 32'h0, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h0, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, 32'h4, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h4, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, 32'h8, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h8, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, 32'hC, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'hC, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,1,32'h1000,0, 2'd1, 32'h1000, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h1000, 0));
    vecs.push_back(v(1,0,1,1,16'hFFFF,0,26'h0,0,32'h0,0, 2'd1, 32'h1000, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h1000, 0));
    vecs.push_back(v(1,0,1,1,16'h0003,0,26'h0,0,32'h0,0, 2'd1, 32'h1010, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h1010, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,1,32'h3000_0000,0, 2'd1, 32'h3000_0000, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h3000_0000, 0));
    vecs.push_back(v(1,0,1,1,16'h0005,1,26'h10,0,32'h0,0, 2'd1, 32'h3000_0040, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h3000_0040, 0));
    vecs.push_back(v(1,0,1,0,16'h0,1,26'h3,1,32'h2002,0, 2'd1, tpc, TRAP_EN));
    vecs.push_back(v(1,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, tpc, 0));
    vecs.push_back(v(1,0,1,1,16'h7,0,26'h0,1,32'h44,0, 2'd1, tpc, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, tpc, 0));
    vecs.push_back(v(1,1,0,1,16'h7,1,26'h5,1,32'h44,1, 2'd2, tpc, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,1,32'hFFFF_FFFC,0, 2'd1, 32'hFFFF_FFFC, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'hFFFF_FFFC, 0));
    vecs.push_back(v(1,0,1,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, 32'h0, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, 32'h0, 0));
    vecs.push_back(v(1,0,1,1,16'h0001,0,26'h0,0,32'h0,1, 2'd3, 32'h8, 0));
    vecs.push_back(v(1,1,1,0,16'h0,0,26'h0,1,32'h100,0, 2'd3, 32'h8, 0));
    vecs.push_back(v(1,1,1,1,16'h9,0,26'h0,0,32'h0,0, 2'd3, 32'h8, 0));
    vecs.push_back(v(0,1,1,0,16'h0,0,26'h0,0,32'h0,0, 2'd0, RV, 0));
    vecs.push_back(v(1,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, RV, 0));
    vecs.push_back(v(0,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd0, RV, 0));
    vecs.push_back(v(1,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd1, RV, 0));
    vecs.push_back(v(1,1,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd2, RV, 0));
    vecs.push_back(v(0,0,1,0,16'h0,0,26'h0,1,32'h40,0, 2'd0, RV, 0));
    r = v(0,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd0, 32'h0, 0);
    apply(r);
    m_st = 0; m_pc = RV; m_trap = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].es), vecs[i].epc, vecs[i].et);
    end
    // Trap pulse lasts exactly one cycle: re-enter EXEC and take a misaligned jr, then hold in FETCH.
    apply(v(1,0,0,0,16'h0,0,26'h0,0,32'h0,0, 2'd0, 32'h0, 0)); tick();
    bus.fetch_ack = 1'b1; tick();
    bus.fetch_ack = 1'b0; bus.commit = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h0000_0503; tick();
    chk_all("mis_jr", 1, TRAP_EN ? TV : 32'h500, TRAP_EN);
    bus.commit = 1'b0; bus.jr = 1'b0; tick();
    chk_all("mis_jr_after", 1, TRAP_EN ? TV : 32'h500, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      bus.fetch_ack = ($urandom_range(0, 2) != 0);
      bus.commit = ($urandom_range(0, 2) != 0);
      bus.br_taken = $urandom_range(0, 1);
      bus.br_imm = 16'($urandom);
      bus.jmp = ($urandom_range(0, 3) == 0);
      bus.jmp_target = 26'($urandom);
      bus.jr = ($urandom_range(0, 3) == 0);
      bus.jr_addr = $urandom;
      bus.halt = ($urandom_range(0, 15) == 0);
      tick();
      chk_all("rand", m_st, m_pc, m_trap);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
